// File: rtl/axi4_lite_master_ctrl.sv
// ---------------------------------------------------------------------------
// axi4_lite_master_ctrl
// Single-outstanding AXI4-Lite master. A one-cycle start pulse launches either
// a write (AW + W, then B) or a read (AR, then R). When the transaction ends,
// the response is returned together with a one-cycle done pulse. A watchdog
// counter aborts any phase that stalls for TIMEOUT cycles without a handshake.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module axi4_lite_master_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    wr_rd,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              resp,
    output logic                    timeout,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    // Counter only has to reach TIMEOUT-1; keep at least one bit.
    localparam int CNT_WIDTH  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : {CNT_WIDTH{1'b0}};
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WR_ADDR_DATA = 3'd1,
        S_WR_RESP      = 3'd2,
        S_RD_ADDR      = 3'd3,
        S_RD_DATA      = 3'd4
    } state_t;

    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_timeout;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_resp;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic                    r_awvalid;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_wvalid;
    logic                    r_bready;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic                    r_arvalid;
    logic                    r_rready;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_any_hs;
    logic w_wr_both;
    logic w_abort;

    // A handshake can only occur in the state that owns the valid/ready, so
    // these need no further state qualification.
    assign w_aw_hs  = r_awvalid & m_axi_awready;
    assign w_w_hs   = r_wvalid  & m_axi_wready;
    assign w_b_hs   = r_bready  & m_axi_bvalid;
    assign w_ar_hs  = r_arvalid & m_axi_arready;
    assign w_r_hs   = r_rready  & m_axi_rvalid;
    assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;

    // In the address/data phase a low valid means that channel already
    // handshook, so both are finished once each is either low or completing.
    assign w_wr_both = (w_aw_hs | ~r_awvalid) & (w_w_hs | ~r_wvalid);

    // Watchdog fires only when a phase is stalled; a handshake on the same
    // cycle always wins.
    assign w_abort = (TIMEOUT != 0) && (r_state != S_IDLE) && !w_any_hs &&
                     (r_cnt == CNT_LAST);

    // Transaction FSM: sequences the AXI channels and owns every output flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CNT_WIDTH{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_rdata   <= {DATA_WIDTH{1'b0}};
            r_resp    <= 2'b00;
            r_awaddr  <= {ADDR_WIDTH{1'b0}};
            r_awvalid <= 1'b0;
            r_wdata   <= {DATA_WIDTH{1'b0}};
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_araddr  <= {ADDR_WIDTH{1'b0}};
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else if (w_abort) begin
            r_state   <= S_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_resp    <= RESP_SLVERR;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_cnt  <= {CNT_WIDTH{1'b0}};
                        if (wr_rd) begin
                            r_awaddr  <= addr;
                            r_wdata   <= wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_ADDR_DATA;
                        end else begin
                            r_araddr  <= addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_WR_ADDR_DATA: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end else begin
                        r_awvalid <= r_awvalid;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end else begin
                        r_wvalid <= r_wvalid;
                    end
                    if (w_wr_both) begin
                        r_bready <= 1'b1;
                        r_cnt    <= {CNT_WIDTH{1'b0}};
                        r_state  <= S_WR_RESP;
                    end else if (w_aw_hs || w_w_hs) begin
                        r_cnt <= {CNT_WIDTH{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                S_WR_RESP: begin
                    if (w_b_hs) begin
                        r_resp   <= m_axi_bresp;
                        r_bready <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                S_RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= {CNT_WIDTH{1'b0}};
                        r_state   <= S_RD_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                S_RD_DATA: begin
                    if (w_r_hs) begin
                        r_rdata  <= m_axi_rdata;
                        r_resp   <= m_axi_rresp;
                        r_rready <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_bready  <= 1'b0;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign rdata         = r_rdata;
    assign resp          = r_resp;
    assign timeout       = r_timeout;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = {STRB_WIDTH{1'b1}};
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for axi4_lite_master_ctrl. A latency-configurable AXI4-Lite slave with
// its own memory answers the master. A timeline model predicts, from the
// command and configured slave latencies, every cycle's busy/done/valid/ready
// and the returned data; a compare process checks it every cycle.
// ---------------------------------------------------------------------------
module tb_axi4_lite_master_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        wr_rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        timeout;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = 32'h0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    axi4_lite_master_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .wr_rd         (wr_rd),
        .addr          (addr),
        .wdata         (wdata),
        .busy          (busy),
        .done          (done),
        .rdata         (rdata),
        .resp          (resp),
        .timeout       (timeout),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Slave configuration: cycles of stall before each ready/valid; -1 = never.
    int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;

    // Observation counters.
    int done_cnt = 0, aw_cyc = 0, w_cyc = 0, b_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_dflt(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Cycle counter.
    always @(posedge clk) cyc++;

    // ---------------- slave ----------------
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] s_awaddr = 32'h0, s_wdata = 32'h0, s_araddr = 32'h0;
    bit          got_aw = 1'b0, got_w = 1'b0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;

    // Slave: capture handshaken payloads and commit writes to its memory.
    always @(posedge clk) begin
        if (rst) begin
            got_aw = 1'b0;
            got_w  = 1'b0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin s_awaddr = m_axi_awaddr; got_aw = 1'b1; end
            if (m_axi_wvalid && m_axi_wready)   begin s_wdata  = m_axi_wdata;  got_w  = 1'b1; end
            if (got_aw && got_w) begin
                slave_mem[s_awaddr] = s_wdata;
                got_aw = 1'b0;
                got_w  = 1'b0;
            end
            if (m_axi_arvalid && m_axi_arready) s_araddr = m_axi_araddr;
        end
    end

    // Slave: drive readies and responses after the configured stall.
    always @(negedge clk) begin
        if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_lat); aw_wait++; end
        else begin m_axi_awready = 1'b0; aw_wait = 0; end
        if (m_axi_wvalid) begin m_axi_wready = (w_wait >= w_lat); w_wait++; end
        else begin m_axi_wready = 1'b0; w_wait = 0; end
        if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= ar_lat); ar_wait++; end
        else begin m_axi_arready = 1'b0; ar_wait = 0; end
        if (m_axi_bready && b_lat >= 0) begin
            m_axi_bvalid = (b_wait >= b_lat); m_axi_bresp = cfg_bresp; b_wait++;
        end else begin
            m_axi_bvalid = 1'b0; b_wait = 0;
        end
        if (m_axi_rready && r_lat >= 0) begin
            m_axi_rvalid = (r_wait >= r_lat); m_axi_rresp = cfg_rresp;
            m_axi_rdata  = slave_mem.exists(s_araddr) ? slave_mem[s_araddr] : mem_dflt(s_araddr);
            r_wait++;
        end else begin
            m_axi_rvalid = 1'b0; r_wait = 0;
        end
    end

    // ---------------- timeline model ----------------
    logic [31:0] model_mem [logic [31:0]];
    bit          m_init = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_to = 1'b0;
    bit          m_wr = 1'b0, m_timed = 1'b0;
    int          m_t = 0, m_a_last = 0, m_w_last = 0, m_p0 = 0, m_tdone = 0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rdata = 32'h0;
    logic [1:0]  m_resp = 2'b00, m_bresp = 2'b00, m_rresp = 2'b00;

    // Model: advance the expected transaction timeline once per cycle.
    always @(posedge clk) begin
        int rl;
        if (rst) begin
            m_init = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_to = 1'b0;
            m_t = 0; m_resp = 2'b00; m_rdata = 32'h0;
        end else begin
            m_done = 1'b0;
            m_to   = 1'b0;
            if (m_busy) begin
                m_t++;
                if (m_t == m_tdone) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    if (m_timed) begin
                        m_to = 1'b1; m_resp = 2'b10;
                    end else if (m_wr) begin
                        m_resp = m_bresp; model_mem[m_addr] = m_wdata;
                    end else begin
                        m_resp  = m_rresp;
                        m_rdata = model_mem.exists(m_addr) ? model_mem[m_addr] : mem_dflt(m_addr);
                    end
                end
            end else if (start) begin
                m_busy = 1'b1; m_t = 1;
                m_wr = wr_rd; m_addr = addr; m_wdata = wdata;
                m_bresp = cfg_bresp; m_rresp = cfg_rresp;
                if (wr_rd) begin
                    m_a_last = 1 + aw_lat;
                    m_w_last = 1 + w_lat;
                    m_p0     = 2 + ((aw_lat > w_lat) ? aw_lat : w_lat);
                    rl       = b_lat;
                end else begin
                    m_a_last = 1 + ar_lat;
                    m_w_last = 0;
                    m_p0     = 2 + ar_lat;
                    rl       = r_lat;
                end
                if (rl >= 0 && rl < TO) begin m_tdone = m_p0 + rl + 1; m_timed = 1'b0; end
                else begin m_tdone = m_p0 + TO; m_timed = 1'b1; end
            end
        end
    end

    // Compare: check every DUT output against the model each cycle.
    always @(negedge clk) begin
        bit e_aw, e_w, e_b, e_ar, e_r;
        if (m_init) begin
            e_aw = m_busy &&  m_wr && (m_t <= m_a_last);
            e_w  = m_busy &&  m_wr && (m_t <= m_w_last);
            e_b  = m_busy &&  m_wr && (m_t >= m_p0);
            e_ar = m_busy && !m_wr && (m_t <= m_a_last);
            e_r  = m_busy && !m_wr && (m_t >= m_p0);
            chk("busy",    64'(busy),          64'(m_busy));
            chk("done",    64'(done),          64'(m_done));
            chk("timeout", 64'(timeout),       64'(m_to));
            chk("awvalid", 64'(m_axi_awvalid), 64'(e_aw));
            chk("wvalid",  64'(m_axi_wvalid),  64'(e_w));
            chk("bready",  64'(m_axi_bready),  64'(e_b));
            chk("arvalid", 64'(m_axi_arvalid), 64'(e_ar));
            chk("rready",  64'(m_axi_rready),  64'(e_r));
            chk("resp",    64'(resp),          64'(m_resp));
            chk("rdata",   64'(rdata),         64'(m_rdata));
            chk("wstrb",   64'(m_axi_wstrb),   64'(4'hF));
            if (e_aw) chk("awaddr", 64'(m_axi_awaddr), 64'(m_addr));
            if (e_w)  chk("wdata",  64'(m_axi_wdata),  64'(m_wdata));
            if (e_ar) chk("araddr", 64'(m_axi_araddr), 64'(m_addr));
            if (done === 1'b1)          done_cnt++;
            if (m_axi_awvalid === 1'b1) aw_cyc++;
            if (m_axi_wvalid === 1'b1)  w_cyc++;
            if (m_axi_bready === 1'b1)  b_cyc++;
        end
    end

    // Issue one command at a negedge and wait (bounded) for its done pulse.
    task automatic run_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d, output int lat);
        int  c0;
        bit  seen;
        aw_cyc = 0; w_cyc = 0; b_cyc = 0;
        start = 1'b1; wr_rd = wr; addr = a; wdata = d;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        lat   = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - c0;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL run_cmd_no_done actual=none required=done addr=%0h", a);
        end
    endtask

    int lat, base;

    initial begin
        rst = 1'b1; start = 1'b0; wr_rd = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    64'(busy),          64'(0));
        chk("rst_done",    64'(done),          64'(0));
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'(0));
        chk("rst_awaddr",  64'(m_axi_awaddr),  64'(0));
        chk("rst_rdata",   64'(rdata),         64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Write with zero-latency slave.
        run_cmd(1'b1, 32'h10, 32'hA5A5_0001, lat);
        chk("wr1_lat",        64'(lat),    64'(3));
        chk("wr1_resp",       64'(resp),   64'(2'b00));
        chk("wr1_aw_cycles",  64'(aw_cyc), 64'(1));
        chk("wr1_w_cycles",   64'(w_cyc),  64'(1));
        chk("wr1_busy_done",  64'(busy),   64'(0));
        @(negedge clk);

        // Read back.
        base = done_cnt;
        run_cmd(1'b0, 32'h10, 32'h0, lat);
        chk("rd1_lat",       64'(lat),   64'(3));
        chk("rd1_rdata",     64'(rdata), 64'(32'hA5A5_0001));
        chk("rd1_resp",      64'(resp),  64'(2'b00));
        chk("rd1_busy_done", 64'(busy),  64'(0));
        @(negedge clk);
        chk("rd1_done_once", 64'(done_cnt - base), 64'(1));

        // Write with wready four cycles after awready.
        w_lat = 4;
        base  = done_cnt;
        run_cmd(1'b1, 32'h20, 32'h1234_5678, lat);
        chk("wr2_lat",       64'(lat),    64'(7));
        chk("wr2_aw_cycles", 64'(aw_cyc), 64'(1));
        chk("wr2_w_cycles",  64'(w_cyc),  64'(5));
        w_lat = 0;
        repeat (3) @(negedge clk);
        chk("wr2_single_done", 64'(done_cnt - base), 64'(1));

        // Read with stalled AR and R, non-OKAY response.
        ar_lat = 1; r_lat = 2; cfg_rresp = 2'b11;
        run_cmd(1'b0, 32'h20, 32'h0, lat);
        chk("rd2_lat",   64'(lat),   64'(6));
        chk("rd2_resp",  64'(resp),  64'(2'b11));
        chk("rd2_rdata", 64'(rdata), 64'(32'h1234_5678));
        ar_lat = 0; r_lat = 0; cfg_rresp = 2'b00;
        @(negedge clk);

        // B arrives on the last cycle before the watchdog would fire.
        b_lat = TO - 1; cfg_bresp = 2'b01;
        run_cmd(1'b1, 32'h40, 32'h0BAD_F00D, lat);
        chk("wr3_lat",     64'(lat),     64'(18));
        chk("wr3_resp",    64'(resp),    64'(2'b01));
        chk("wr3_timeout", 64'(timeout), 64'(0));
        chk("wr3_b_cycles",64'(b_cyc),   64'(16));
        cfg_bresp = 2'b00;
        @(negedge clk);

        // B never arrives: watchdog abort.
        b_lat = -1;
        run_cmd(1'b1, 32'h30, 32'h5555_AAAA, lat);
        chk("wr4_lat",      64'(lat),     64'(18));
        chk("wr4_resp",     64'(resp),    64'(2'b10));
        chk("wr4_timeout",  64'(timeout), 64'(1));
        chk("wr4_b_cycles", 64'(b_cyc),   64'(16));
        b_lat = 0;
        @(negedge clk);
        chk("wr4_bready_after", 64'(m_axi_bready), 64'(0));
        chk("wr4_done_after",   64'(done),         64'(0));

        // start held high: back-to-back reads, one per done.
        base  = done_cnt;
        start = 1'b1; wr_rd = 1'b0; addr = 32'h10;
        repeat (12) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("b2b_count", 64'(done_cnt - base), 64'(4));
        chk("b2b_rdata", 64'(rdata),           64'(32'hA5A5_0001));

        // Reset while arvalid is high.
        ar_lat = 5;
        base   = done_cnt;
        start  = 1'b1; wr_rd = 1'b0; addr = 32'h20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rstmid_arvalid_pre", 64'(m_axi_arvalid), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_arvalid", 64'(m_axi_arvalid), 64'(0));
        chk("rstmid_busy",    64'(busy),          64'(0));
        rst    = 1'b0;
        ar_lat = 0;
        repeat (3) @(negedge clk);
        chk("rstmid_no_done", 64'(done_cnt - base), 64'(0));
        run_cmd(1'b0, 32'h20, 32'h0, lat);
        chk("rd3_lat",   64'(lat),   64'(3));
        chk("rd3_rdata", 64'(rdata), 64'(32'h1234_5678));
        chk("rd3_resp",  64'(resp),  64'(2'b00));
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
